wide_alu_seq: RTL and testbench
===============================

# wide_alu_seq

Multi-byte operation sequencer for the 8-bit combinational ALU. It accepts one NB-byte operation (add, subtract, shift left, shift right) through a start/done handshake and drives the ALU one byte per cycle. It chains the ALU carry/shift bit between bytes and assembles the wide result, status flags and final carry. It sits between the core control logic and the shared ALU instance, and owns the ALU's input ports while busy.

## Interface
- W, 8, ALU byte width (fixed to match the ALU)
- NB, 4, number of bytes per wide operation (2..8)

- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  request pulse/level; sampled only in IDLE or DONE
- Op  input  2  00 ADD, 01 SUB, 10 LSH (logical), 11 RSH (logical)
- A  input  NB*W  operand A, byte 0 = bits [W-1:0]
- B  input  NB*W  operand B (ignored for LSH/RSH)
- Busy  output  1  high while in RUN
- Done  output  1  one-cycle pulse when Result is valid
- Result  output  NB*W  wide result, held until the next accepted Start
- CarryOut  output  1  final carry (ADD), no-borrow (SUB), or the bit shifted out (LSH/RSH)
- Zero  output  1  Result == 0, registered together with Result
- AluA  output  W  byte to ALU InputA
- AluB  output  W  byte to ALU InputB
- AluOP  output  op_mne  ALU opcode (Definitions package)
- AluSCin  output  1  ALU SC_in
- AluOut  input  W  ALU Out
- AluSCout  input  1  ALU SC_out

## Operation
- FSM states: IDLE, RUN, DONE. Reset and illegal state encodings go to IDLE.
- **Accepting a request.** In IDLE or DONE, Start=1 at a rising edge:
  - latch A, B and Op into internal registers;
  - load the byte index: 0 for ADD/SUB/LSH, NB-1 for RSH;
  - load the carry register: 1 for SUB, 0 for all other ops;
  - clear Result and go to RUN.
- **Ignoring Start.** Start is ignored while in RUN. Operand inputs may change freely after acceptance.
- **RUN datapath.** AluA, AluB, AluOP and AluSCin are combinational from the latched operands, the index and the carry register:
  - ADD: AluOP=ADD, AluA=A[idx], AluB=B[idx], AluSCin=carry.
  - SUB: AluOP=ADD, AluA=A[idx], AluB=~B[idx], AluSCin=carry. The ALU SUB op is not used because it forces +1 on every byte.
  - LSH: AluOP=LSH, AluA=A[idx], AluSCin=carry. Index runs LSB to MSB.
  - RSH: AluOP=RSH, AluA=A[idx], AluSCin=carry. Index runs MSB to LSB.
- **Each RUN edge:**
  - write Result byte idx <= AluOut;
  - carry <= AluSCout;
  - step idx (+1, or -1 for RSH).
  - After the NB-th byte: CarryOut <= AluSCout, Zero <= (final Result == 0), go to DONE.
- **DONE.** Done=1 for exactly one cycle. Without Start the FSM returns to IDLE at the next edge; with Start it goes directly to RUN (back-to-back operation).
- **ALU drive outside RUN:** AluA=0, AluB=0, AluSCin=0, AluOP=ADD.
- **Arithmetic.** Unsigned modulo 2^(NB*W); no overflow flag. For SUB, CarryOut=1 means A>=B.

## Timing
- Reset (asynchronous, immediate) state:
  - FSM in IDLE; Busy=0, Done=0;
  - Result=0, CarryOut=0, Zero=1;
  - ALU drive at its idle values.
- Reset asserted mid-RUN aborts the operation. No Done is produced, and the first legal Start after release begins a fresh operation.
- Latency: Start accepted at edge E0 → Busy=1 from E0 through E0+NB → Done=1 in the cycle after edge E0+NB. Total NB+1 cycles Start-to-Done.
- Result, CarryOut and Zero are stable from the Done cycle until the next accepted Start.
- Throughput with back-to-back Start in DONE: one operation every NB+1 cycles.
- The ALU is combinational, so the ALU path (AluA/AluB/AluOP/AluSCin → ALU → AluOut/AluSCout) is a single-cycle path into the Result/carry registers.

## Test plan
- **ADD.** NB=4, ADD, A=0xFFFFFFFF, B=0x00000001 → Result=0x00000000, CarryOut=1, Zero=1. Done exactly 5 cycles after the Start edge; Busy high for 4 cycles.
- **SUB.** A=0x00000000, B=0x00000001 → Result=0xFFFFFFFF, CarryOut=0. Then A=0x12345678, B=0x02345678 → 0x10000000, CarryOut=1, Zero=0.
- **Shifts.** LSH A=0x80000001 → 0x00000002, CarryOut=1. RSH A=0x00000003 → 0x00000001, CarryOut=1. RSH A=0x80000000 → 0x40000000, CarryOut=0.
- **Start during RUN.** Start pulsed at every edge while Busy=1 → ignored; exactly one Done and the result of the first request. Start held high through DONE → second operation begins with no IDLE cycle.
- **Reset mid-RUN.** Reset_n low two cycles into an ADD → immediately Busy=0, Done=0, Result=0, Zero=1; no Done after release. A new ADD 0x00000005+0x00000007 → 0x0000000C.
- **ALU port monitor.** Check AluOP, AluSCin and byte order each RUN cycle against the rules above. Check the idle ALU drive values (0/0/0/ADD) outside RUN.

Source files
------------

// File: rtl/wide_alu_seq_if.sv
// -----------------------------------------------------------------------------
// Definitions: opcode types shared by the 8-bit ALU and the wide sequencer.
//   op_mne    : opcode presented on the ALU's OP input
//   wide_op_e : wide-operation code requested by core control
//
// wide_alu_seq_if: request/result handshake between core control and the
// sequencer, plus the byte-wide port pair to the shared combinational ALU.
//   master : core control + ALU side (drives Start/Op/A/B and AluOut/AluSCout)
//   slave  : the sequencer (drives Busy/Done/Result/flags and the ALU inputs)
// -----------------------------------------------------------------------------
package Definitions;
  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    LSH = 2'b10,
    RSH = 2'b11
  } op_mne;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LSH = 2'b10,
    OP_RSH = 2'b11
  } wide_op_e;
endpackage

interface wide_alu_seq_if #(
  parameter int W  = 8,
  parameter int NB = 4
);
  import Definitions::*;

  // Core-control request and result
  logic            Start;
  logic [1:0]      Op;
  logic [NB*W-1:0] A;
  logic [NB*W-1:0] B;
  logic            Busy;
  logic            Done;
  logic [NB*W-1:0] Result;
  logic            CarryOut;
  logic            Zero;

  // Shared ALU ports
  logic [W-1:0]    AluA;
  logic [W-1:0]    AluB;
  op_mne           AluOP;
  logic            AluSCin;
  logic [W-1:0]    AluOut;
  logic            AluSCout;

  modport master (
    output Start, Op, A, B, AluOut, AluSCout,
    input  Busy, Done, Result, CarryOut, Zero, AluA, AluB, AluOP, AluSCin
  );

  modport slave (
    input  Start, Op, A, B, AluOut, AluSCout,
    output Busy, Done, Result, CarryOut, Zero, AluA, AluB, AluOP, AluSCin
  );
endinterface

// File: rtl/wide_alu_seq.sv
// -----------------------------------------------------------------------------
// wide_alu_seq: runs one NB-byte ADD/SUB/LSH/RSH through the shared 8-bit
// combinational ALU, one byte per clock, chaining carry/shift bits between
// bytes and assembling the wide result, Zero flag and final carry.
//
// Ports:
//   Clk     : rising-edge clock
//   Reset_n : asynchronous active-low reset
//   bus     : wide_alu_seq_if.slave (Start/Op/A/B in, Busy/Done/Result/
//             CarryOut/Zero out, AluA/AluB/AluOP/AluSCin out,
//             AluOut/AluSCout in)
//
// Start is accepted in IDLE or DONE; Done pulses NB+1 cycles later. Holding
// Start through DONE chains operations with no idle cycle.
// -----------------------------------------------------------------------------
module wide_alu_seq #(
  parameter int W  = 8,
  parameter int NB = 4
) (
  input  logic          Clk,
  input  logic          Reset_n,
  wide_alu_seq_if.slave bus
);
  import Definitions::*;

  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e                 state_q;
  wide_op_e               op_q;
  logic [IW-1:0]          idx_q;
  logic                   carry_q;
  logic [NB-1:0][W-1:0]   a_q;
  logic [NB-1:0][W-1:0]   b_q;
  logic [NB-1:0][W-1:0]   result_q;
  logic                   carry_out_q;
  logic                   zero_q;
  logic                   busy_q;
  logic                   done_q;

  logic [NB-1:0][W-1:0]   result_d;
  logic                   last_byte;

  // RSH walks MSB to LSB, everything else LSB to MSB.
  assign last_byte = (op_q == OP_RSH) ? (idx_q == '0) : (idx_q == LAST_IDX);

  // ALU drive plus the result with the current byte merged in. Zero must see
  // the final byte, so it is computed from this merged value, not result_q.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    bus.AluA    = '0;
    bus.AluB    = '0;
    bus.AluOP   = ADD;
    bus.AluSCin = 1'b0;
    result_d    = result_q;
    result_d[idx_q] = bus.AluOut;

    if (state_q == S_RUN) begin
      bus.AluA    = a_q[idx_q];
      bus.AluSCin = carry_q;
      unique case (op_q)
        OP_ADD: begin
          bus.AluOP = ADD;
          bus.AluB  = b_q[idx_q];
        end
        // A - B = A + ~B + 1; the +1 enters once via the carry preset at
        // accept. The ALU's own SUB would add 1 on every byte.
        OP_SUB: begin
          bus.AluOP = ADD;
          bus.AluB  = ~b_q[idx_q];
        end
        OP_LSH: bus.AluOP = LSH;
        OP_RSH: bus.AluOP = RSH;
      endcase
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge values and the order of statements below does not matter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      // NOTE: the operand registers are reset too; they are only a few flops
      // and it keeps the ALU inputs free of X after reset.
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            op_q     <= wide_op_e'(bus.Op);
            a_q      <= bus.A;
            b_q      <= bus.B;
            idx_q    <= (wide_op_e'(bus.Op) == OP_RSH) ? LAST_IDX : '0;
            carry_q  <= (wide_op_e'(bus.Op) == OP_SUB);
            result_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          result_q <= result_d;
          carry_q  <= bus.AluSCout;
          idx_q    <= (op_q == OP_RSH) ? idx_q - 1'b1 : idx_q + 1'b1;
          if (last_byte) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            carry_out_q <= bus.AluSCout;
            zero_q      <= (result_d == '0);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Result   = result_q;
  assign bus.CarryOut = carry_out_q;
  assign bus.Zero     = zero_q;

endmodule

// File: tb/tb_wide_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_alu_seq: directed bench for wide_alu_seq (NB=4, W=8) with a
// behavioural model of the 8-bit combinational ALU on the ALU ports.
// -----------------------------------------------------------------------------
module tb_wide_alu_seq;
  import Definitions::*;

  localparam int W  = 8;
  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  wide_alu_seq_if #(.W(W), .NB(NB)) bus ();

  wide_alu_seq #(.W(W), .NB(NB)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // 8-bit combinational ALU model
  always_comb begin
    bus.AluOut   = '0;
    bus.AluSCout = 1'b0;
    case (bus.AluOP)
      ADD: {bus.AluSCout, bus.AluOut} = {1'b0, bus.AluA} + {1'b0, bus.AluB} + {8'd0, bus.AluSCin};
      SUB: {bus.AluSCout, bus.AluOut} = {1'b0, bus.AluA} + {1'b0, ~bus.AluB} + 9'd1;
      LSH: {bus.AluSCout, bus.AluOut} = {bus.AluA, bus.AluSCin};
      RSH: {bus.AluOut, bus.AluSCout} = {bus.AluSCin, bus.AluA};
      default: ;
    endcase
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request, scramble the operand inputs after acceptance, then wait
  // (bounded) for Done. done_n is the cycle after the accept edge in which
  // Done was seen (1 = first cycle after the edge), 0 if never seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_n, output int done_n);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.Op = ~op; bus.A = ~a; bus.B = ~b;
    busy_n = 0;
    done_n = 0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.Busy) busy_n++;
      if (bus.Done) begin
        done_n = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.Start = 1'b0; bus.Op = 2'b00; bus.A = '0; bus.B = '0;
    #12;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.Done); end
    checks++; if (bus.Result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 00000000", bus.Result); end
    checks++; if (bus.CarryOut !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus.CarryOut); end
    checks++; if (bus.Zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", bus.Zero); end
    checks++;
    if ({bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP} !== {8'h00, 8'h00, 1'b0, ADD}) begin
      errors++; $display("FAIL reset_alu_drive: got A=%h B=%h SCin=%b OP=%0d want 00/00/0/ADD",
                         bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset_busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_add();
    int busy_n, done_n;
    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, busy_n, done_n);
    checks++; if (done_n != 5) begin errors++; $display("FAIL add_latency: got done in cycle %0d want 5", done_n); end
    checks++; if (busy_n != 4) begin errors++; $display("FAIL add_busy_cycles: got %0d want 4", busy_n); end
    checks++; if (bus.Result !== 32'h0) begin errors++; $display("FAIL add_wrap_result: got %h want 00000000", bus.Result); end
    checks++; if (bus.CarryOut !== 1'b1) begin errors++; $display("FAIL add_wrap_carry: got %b want 1", bus.CarryOut); end
    checks++; if (bus.Zero !== 1'b1) begin errors++; $display("FAIL add_wrap_zero: got %b want 1", bus.Zero); end
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL add_done_width: got %b want 0", bus.Done); end
    checks++; if (bus.CarryOut !== 1'b1) begin errors++; $display("FAIL add_carry_held: got %b want 1", bus.CarryOut); end

    run_op(2'b00, 32'h1234_5678, 32'h1111_1111, busy_n, done_n);
    checks++; if (done_n != 5) begin errors++; $display("FAIL add2_latency: got %0d want 5", done_n); end
    checks++; if (bus.Result !== 32'h2345_6789) begin errors++; $display("FAIL add2_result: got %h want 23456789", bus.Result); end
    checks++; if ({bus.CarryOut, bus.Zero} !== 2'b00) begin errors++; $display("FAIL add2_flags: got C=%b Z=%b want 0/0", bus.CarryOut, bus.Zero); end
  endtask

  // Shared vector loop for SUB and shift tables
  task automatic run_table(input int count, input logic [1:0] ops[4], input logic [31:0] as[4],
                           input logic [31:0] bs[4], input logic [31:0] rs[4],
                           input logic cs[4], input logic zs[4]);
    int busy_n, done_n;
    for (int i = 0; i < count; i++) begin
      run_op(ops[i], as[i], bs[i], busy_n, done_n);
      checks++;
      if (done_n != 5 || bus.Result !== rs[i] || bus.CarryOut !== cs[i] || bus.Zero !== zs[i]) begin
        errors++;
        $display("FAIL vec op=%0d A=%h B=%h: got done@%0d R=%h C=%b Z=%b want done@5 R=%h C=%b Z=%b",
                 ops[i], as[i], bs[i], done_n, bus.Result, bus.CarryOut, bus.Zero, rs[i], cs[i], zs[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [1:0]  ops[4];
    logic [31:0] as[4], bs[4], rs[4];
    logic        cs[4], zs[4];
    ops[0] = 2'b01; as[0] = 32'h0000_0000; bs[0] = 32'h0000_0001; rs[0] = 32'hFFFF_FFFF; cs[0] = 0; zs[0] = 0;
    ops[1] = 2'b01; as[1] = 32'h1234_5678; bs[1] = 32'h0234_5678; rs[1] = 32'h1000_0000; cs[1] = 1; zs[1] = 0;
    ops[2] = 2'b01; as[2] = 32'h0000_0005; bs[2] = 32'h0000_0005; rs[2] = 32'h0000_0000; cs[2] = 1; zs[2] = 1;
    ops[3] = 2'b01; as[3] = 32'h8000_0000; bs[3] = 32'h0000_0001; rs[3] = 32'h7FFF_FFFF; cs[3] = 1; zs[3] = 0;
    run_table(4, ops, as, bs, rs, cs, zs);
  endtask

  task automatic test_shifts();
    logic [1:0]  ops[4];
    logic [31:0] as[4], bs[4], rs[4];
    logic        cs[4], zs[4];
    ops[0] = 2'b10; as[0] = 32'h8000_0001; bs[0] = 32'hDEAD_BEEF; rs[0] = 32'h0000_0002; cs[0] = 1; zs[0] = 0;
    ops[1] = 2'b11; as[1] = 32'h0000_0003; bs[1] = 32'hDEAD_BEEF; rs[1] = 32'h0000_0001; cs[1] = 1; zs[1] = 0;
    ops[2] = 2'b11; as[2] = 32'h8000_0000; bs[2] = 32'hDEAD_BEEF; rs[2] = 32'h4000_0000; cs[2] = 0; zs[2] = 0;
    ops[3] = 2'b10; as[3] = 32'h8000_0000; bs[3] = 32'hDEAD_BEEF; rs[3] = 32'h0000_0000; cs[3] = 1; zs[3] = 1;
    run_table(4, ops, as, bs, rs, cs, zs);
  endtask

  // Per-cycle ALU port check: byte order, opcode, carry chain, B inversion.
  task automatic test_alu_ports();
    logic [1:0]  ops[3];
    logic [31:0] as[3], bs[3], rs[3];
    logic        couts[3], chk_b[3];
    op_mne       eop[3];
    logic [7:0]  ea[3][4], eb[3][4];
    logic        ec[3][4];

    // RSH 0x81020304: bytes MSB first, shift bit chained downwards
    ops[0] = 2'b11; as[0] = 32'h8102_0304; bs[0] = 32'hFFFF_FFFF; rs[0] = 32'h4081_0182;
    couts[0] = 1'b0; eop[0] = RSH; chk_b[0] = 1'b0;
    ea[0][0] = 8'h81; ea[0][1] = 8'h02; ea[0][2] = 8'h03; ea[0][3] = 8'h04;
    ec[0][0] = 1'b0;  ec[0][1] = 1'b1;  ec[0][2] = 1'b0;  ec[0][3] = 1'b1;
    eb[0][0] = 8'h00; eb[0][1] = 8'h00; eb[0][2] = 8'h00; eb[0][3] = 8'h00;
    // SUB 0x100 - 1: ADD opcode, inverted B, initial carry 1
    ops[1] = 2'b01; as[1] = 32'h0000_0100; bs[1] = 32'h0000_0001; rs[1] = 32'h0000_00FF;
    couts[1] = 1'b1; eop[1] = ADD; chk_b[1] = 1'b1;
    ea[1][0] = 8'h00; ea[1][1] = 8'h01; ea[1][2] = 8'h00; ea[1][3] = 8'h00;
    eb[1][0] = 8'hFE; eb[1][1] = 8'hFF; eb[1][2] = 8'hFF; eb[1][3] = 8'hFF;
    ec[1][0] = 1'b1;  ec[1][1] = 1'b0;  ec[1][2] = 1'b1;  ec[1][3] = 1'b1;
    // LSH 0x00800180: bytes LSB first, shift bit chained upwards
    ops[2] = 2'b10; as[2] = 32'h0080_0180; bs[2] = 32'h1234_5678; rs[2] = 32'h0100_0300;
    couts[2] = 1'b0; eop[2] = LSH; chk_b[2] = 1'b0;
    ea[2][0] = 8'h80; ea[2][1] = 8'h01; ea[2][2] = 8'h80; ea[2][3] = 8'h00;
    ec[2][0] = 1'b0;  ec[2][1] = 1'b1;  ec[2][2] = 1'b0;  ec[2][3] = 1'b1;
    eb[2][0] = 8'h00; eb[2][1] = 8'h00; eb[2][2] = 8'h00; eb[2][3] = 8'h00;

    @(negedge clk);
    checks++;
    if ({bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP} !== {8'h00, 8'h00, 1'b0, ADD}) begin
      errors++; $display("FAIL idle_alu_drive: got A=%h B=%h SCin=%b OP=%0d want 00/00/0/ADD",
                         bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP);
    end

    for (int s = 0; s < 3; s++) begin
      bus.Start = 1'b1; bus.Op = ops[s]; bus.A = as[s]; bus.B = bs[s];
      @(negedge clk);
      bus.Start = 1'b0; bus.A = 32'h0; bus.B = 32'h0;
      for (int k = 0; k < NB; k++) begin
        checks++;
        if (bus.Busy !== 1'b1 || bus.AluOP !== eop[s] || bus.AluA !== ea[s][k] || bus.AluSCin !== ec[s][k] ||
            (chk_b[s] && bus.AluB !== eb[s][k])) begin
          errors++;
          $display("FAIL alu_port s%0d byte%0d: got busy=%b OP=%0d A=%h B=%h SCin=%b want busy=1 OP=%0d A=%h B=%h SCin=%b",
                   s, k, bus.Busy, bus.AluOP, bus.AluA, bus.AluB, bus.AluSCin, eop[s], ea[s][k], eb[s][k], ec[s][k]);
        end
        @(negedge clk);
      end
      checks++;
      if (bus.Done !== 1'b1 || bus.Result !== rs[s] || bus.CarryOut !== couts[s]) begin
        errors++; $display("FAIL alu_port_result s%0d: got done=%b R=%h C=%b want done=1 R=%h C=%b",
                           s, bus.Done, bus.Result, bus.CarryOut, rs[s], couts[s]);
      end
      checks++;
      if ({bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP} !== {8'h00, 8'h00, 1'b0, ADD}) begin
        errors++; $display("FAIL done_alu_drive s%0d: got A=%h B=%h SCin=%b OP=%0d want 00/00/0/ADD",
                           s, bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_during_run();
    int          dones;
    logic [31:0] res_at_done;
    dones = 0;
    res_at_done = 32'h0;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'h0100_0000; bus.B = 32'h0200_0000;
    @(negedge clk);
    for (int n = 1; n <= 12; n++) begin
      if (bus.Done) begin
        dones++;
        res_at_done = bus.Result;
        bus.Start = 1'b0;
      end else if (bus.Busy) begin
        bus.Start = 1'b1; bus.Op = 2'($urandom_range(0, 3)); bus.A = $urandom; bus.B = $urandom;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_start_dones: got %0d want 1", dones); end
    checks++; if (res_at_done !== 32'h0300_0000) begin errors++; $display("FAIL ignore_start_result: got %h want 03000000", res_at_done); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle: got busy=%b want 0", bus.Busy); end
  endtask

  task automatic test_back_to_back();
    int          d1, d2;
    logic [31:0] r1, r2;
    logic        busy_next, done_next;
    d1 = 0; d2 = 0; r1 = 32'h0; r2 = 32'h0;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'h0000_0001; bus.B = 32'h0000_0002;
    @(negedge clk);
    bus.A = 32'h0000_0010; bus.B = 32'h0000_0020;
    for (int n = 1; n <= 20; n++) begin
      if (bus.Done) begin d1 = n; r1 = bus.Result; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.Start = 1'b0; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    busy_next = bus.Busy;
    done_next = bus.Done;
    for (int n = 1; n <= 20; n++) begin
      if (bus.Done) begin d2 = n; r2 = bus.Result; break; end
      @(negedge clk);
    end
    checks++; if (d1 != 5) begin errors++; $display("FAIL b2b_first_latency: got %0d want 5", d1); end
    checks++; if (r1 !== 32'h0000_0003) begin errors++; $display("FAIL b2b_first_result: got %h want 00000003", r1); end
    checks++;
    if ({busy_next, done_next} !== 2'b10) begin
      errors++; $display("FAIL b2b_no_idle: got busy=%b done=%b want 1/0", busy_next, done_next);
    end
    checks++; if (d2 != 5) begin errors++; $display("FAIL b2b_second_latency: got %0d want 5", d2); end
    checks++; if (r2 !== 32'h0000_0030) begin errors++; $display("FAIL b2b_second_result: got %h want 00000030", r2); end
  endtask

  task automatic test_reset_mid_run();
    int busy_n, done_n, stray;
    stray = 0;
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'b00; bus.A = 32'h1111_1111; bus.B = 32'h2222_2222;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    checks++; if (bus.Result !== 32'h0000_0033) begin errors++; $display("FAIL midrun_partial: got %h want 00000033", bus.Result); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.Busy, bus.Done, bus.Zero, bus.CarryOut} !== 4'b0010 || bus.Result !== 32'h0) begin
      errors++; $display("FAIL midrun_reset: got busy=%b done=%b Z=%b C=%b R=%h want 0/0/1/0 R=00000000",
                         bus.Busy, bus.Done, bus.Zero, bus.CarryOut, bus.Result);
    end
    checks++;
    if ({bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP} !== {8'h00, 8'h00, 1'b0, ADD}) begin
      errors++; $display("FAIL midrun_alu_drive: got A=%h B=%h SCin=%b OP=%0d want 00/00/0/ADD",
                         bus.AluA, bus.AluB, bus.AluSCin, bus.AluOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrun_no_done: got %0d busy/done cycles want 0", stray); end
    run_op(2'b00, 32'h0000_0005, 32'h0000_0007, busy_n, done_n);
    checks++;
    if (done_n != 5 || bus.Result !== 32'h0000_000C || bus.Zero !== 1'b0 || bus.CarryOut !== 1'b0) begin
      errors++; $display("FAIL midrun_fresh_add: got done@%0d R=%h Z=%b C=%b want done@5 R=0000000c Z=0 C=0",
                         done_n, bus.Result, bus.Zero, bus.CarryOut);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shifts();
    test_alu_ports();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
